// File: rtl/uart_imem_loader.sv
// uart_imem_loader: receives a length-prefixed, big-endian word stream from a
// UART byte receiver and writes it into instruction memory while holding the
// CPU in reset.
// Optional feature: define LOADER_TIMEOUT_EN to abort a session into ERR when
// TIMEOUT_CYCLES clocks pass without a received byte while busy.
`timescale 1ns/1ps

module uart_imem_loader #(
  parameter int ROM_SIZE       = 256,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load_start,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        wr_en,
  output logic [30:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_DONE, S_ERR
  } state_t;

  localparam logic [16:0] LP_ROM = 17'(ROM_SIZE);

  state_t      r_state, w_state_nxt;
  logic [15:0] r_count;
  logic [31:0] r_asm;
  logic [1:0]  r_bcnt;
  logic [28:0] r_word_idx;
  logic        r_wr_en;
  logic [30:0] r_wr_addr;
  logic [31:0] r_wr_data;

  logic [15:0] w_len;
  logic        w_len_big;
  logic [31:0] w_asm_nxt;
  logic        w_last_wr;
  logic        w_accept;
  logic        w_start;
  logic        w_busy;
  logic        w_timeout;

  assign w_len     = {r_count[15:8], rx_data};
  assign w_len_big = {1'b0, w_len} > LP_ROM;
  assign w_asm_nxt = {r_asm[23:0], rx_data};
  // word_idx is bumped together with the write latch, so during the write
  // pulse of the final word it already equals the word count.
  assign w_last_wr = r_wr_en && (r_word_idx == {13'd0, r_count});
  // A byte arriving during the final write pulse belongs to no word; drop it.
  assign w_accept  = (r_state == S_DATA) && rx_valid && !w_last_wr;
  assign w_start   = load_start && (r_state == S_IDLE || r_state == S_ERR);
  assign w_busy    = (r_state == S_LEN_HI) || (r_state == S_LEN_LO) ||
                     (r_state == S_DATA);

`ifdef LOADER_TIMEOUT_EN
  localparam int                LP_TW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [LP_TW-1:0]  LP_TLIM = LP_TW'(TIMEOUT_CYCLES - 1);
  logic [LP_TW-1:0] r_idle_cnt;

  // Idle clock counter: cleared by any byte and whenever no session is busy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                          r_idle_cnt <= '0;
    else if (!w_busy || rx_valid)          r_idle_cnt <= '0;
    else                                   r_idle_cnt <= r_idle_cnt + 1'b1;
  end

  assign w_timeout = w_busy && !rx_valid && (r_idle_cnt == LP_TLIM);
`else
  assign w_timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (load_start) w_state_nxt = S_LEN_HI;
      S_LEN_HI: if (rx_valid)   w_state_nxt = S_LEN_LO;
      S_LEN_LO: if (rx_valid) begin
                  if (w_len == 16'd0)  w_state_nxt = S_DONE;
                  else if (w_len_big)  w_state_nxt = S_ERR;
                  else                 w_state_nxt = S_DATA;
                end
      S_DATA:   if (w_last_wr)  w_state_nxt = S_DONE;
      S_DONE:   w_state_nxt = S_IDLE;
      S_ERR:    if (load_start) w_state_nxt = S_LEN_HI;
      default:  w_state_nxt = S_IDLE;
    endcase
    if (w_timeout && !w_last_wr) w_state_nxt = S_ERR;
  end

  // Datapath: length capture, word assembly and the registered write port.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count    <= '0;
      r_asm      <= '0;
      r_bcnt     <= '0;
      r_word_idx <= '0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
    end else begin
      r_wr_en <= 1'b0;
      if (w_start) begin
        r_count    <= '0;
        r_asm      <= '0;
        r_bcnt     <= '0;
        r_word_idx <= '0;
      end
      if (r_state == S_LEN_HI && rx_valid) r_count[15:8] <= rx_data;
      if (r_state == S_LEN_LO && rx_valid) r_count[7:0]  <= rx_data;
      if (w_accept) begin
        r_asm  <= w_asm_nxt;
        r_bcnt <= r_bcnt + 2'd1;
        if (r_bcnt == 2'd3) begin
          r_wr_en    <= 1'b1;
          r_wr_data  <= w_asm_nxt;
          r_wr_addr  <= {r_word_idx, 2'b00};
          r_word_idx <= r_word_idx + 29'd1;
        end
      end
    end
  end

  assign wr_en    = r_wr_en;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;
  assign busy     = w_busy;
  assign cpu_hold = w_busy || (r_state == S_ERR);
  assign done     = (r_state == S_DONE);
  assign err      = (r_state == S_ERR);

endmodule

// File: tb/tb_uart_imem_loader.sv
// tb_uart_imem_loader: randomized load sessions scored against a stream-level
// model of the loader (length header, big-endian words, ROM bound).
`timescale 1ns/1ps

module tb_uart_imem_loader;
  localparam int ROM = 256;

  logic        clk, reset_n, load_start, rx_valid;
  logic [7:0]  rx_data;
  logic        wr_en, cpu_hold, busy, done, err;
  logic [30:0] wr_addr;
  logic [31:0] wr_data;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0]  tx_q[$];
  logic [62:0] obs_q[$];
  int          done_cnt;
  logic        hold_at_done;

  uart_imem_loader #(.ROM_SIZE(ROM), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset_n(reset_n), .load_start(load_start),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observe outputs on the falling edge.
  always @(negedge clk) begin
    if (wr_en) obs_q.push_back({wr_addr, wr_data});
    if (done) begin
      done_cnt++;
      hold_at_done = cpu_hold;
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_wr_en"},   wr_en,    0);
    chk({tag, "_wr_addr"}, wr_addr,  0);
    chk({tag, "_wr_data"}, wr_data,  0);
    chk({tag, "_hold"},    cpu_hold, 0);
    chk({tag, "_busy"},    busy,     0);
    chk({tag, "_done"},    done,     0);
    chk({tag, "_err"},     err,      0);
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  // Build a stream of n words; an oversize count gets a few stray bytes only.
  task automatic gen(input int n);
    tx_q.delete();
    tx_q.push_back(8'(n >> 8));
    tx_q.push_back(8'(n));
    if (n <= ROM) repeat (4 * n) tx_q.push_back(8'($urandom));
    else          repeat (4)     tx_q.push_back(8'($urandom));
  endtask

  // Run one session from tx_q and score it against the stream model.
  task automatic run_load(input bit noise, input int gap_max);
    int n, k;
    bit exp_err;
    logic [31:0] w;
    logic [62:0] e;
    obs_q.delete();
    done_cnt = 0;
    n = int'({tx_q[0], tx_q[1]});
    exp_err = (n > ROM);
    if (noise) repeat (3) begin
      send(8'($urandom));
      tick();
    end
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    chk("start_hold", cpu_hold, 1);
    chk("start_busy", busy, 1);
    chk("start_err",  err, 0);
    foreach (tx_q[i]) begin
      if (noise && !exp_err && n > 0 && i >= 1)
        load_start = ($urandom_range(0, 3) == 0);
      send(tx_q[i]);
      load_start = 1'b0;
      repeat ($urandom_range(0, gap_max)) tick();
    end
    k = 0;
    while (done_cnt == 0 && !err && k < 100) begin
      tick();
      k++;
    end
    chk("settle_bound", (k < 100), 1);
    repeat (2) tick();
    if (exp_err) begin
      chk("err_flag", err, 1);
      chk("err_hold", cpu_hold, 1);
      chk("err_done", done_cnt, 0);
      chk("err_nowr", obs_q.size(), 0);
    end else begin
      chk("done_cnt", done_cnt, 1);
      chk("done_hold", hold_at_done, 0);
      chk("ok_err", err, 0);
      chk("wr_count", obs_q.size(), n);
      for (int i = 0; i < n && i < obs_q.size(); i++) begin
        w = {tx_q[2+4*i], tx_q[3+4*i], tx_q[4+4*i], tx_q[5+4*i]};
        e = {31'(4 * i), w};
        chk("wr_addr", obs_q[i][62:32], e[62:32]);
        chk("wr_data", obs_q[i][31:0],  e[31:0]);
      end
      if (n > 0) begin
        w = {tx_q[4*n-2], tx_q[4*n-1], tx_q[4*n], tx_q[4*n+1]};
        chk("hold_addr", wr_addr, 31'(4 * (n - 1)));
        chk("hold_data", wr_data, w);
      end
    end
  endtask

  initial begin
    int n, kind;
    reset_n = 1'b0; load_start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    done_cnt = 0; hold_at_done = 1'b0;
    repeat (3) tick();
    chk_idle("reset");
    reset_n = 1'b1;
    tick();

    // Two-word directed stream.
    tx_q = {8'h00, 8'h02, 8'h08, 8'h00, 8'h00, 8'h03, 8'h08, 8'h00, 8'h00, 8'h15};
    run_load(0, 0);
    if (obs_q.size() == 2) begin
      chk("d2_w0", obs_q[0], {31'h0, 32'h08000003});
      chk("d2_w1", obs_q[1], {31'h4, 32'h08000015});
    end

    // Zero-length: done exactly one cycle after the low length byte.
    load_start = 1'b1; tick(); load_start = 1'b0;
    send(8'h00);
    send(8'h00);
    chk("len0_done_now", done, 1);
    chk("len0_hold_now", cpu_hold, 0);
    chk("len0_no_wr", wr_en, 0);
    tick();
    chk("len0_done_gone", done, 0);

    // Oversize count, then a clean session clears err.
    gen(257);
    run_load(0, 1);
    gen(1);
    run_load(0, 1);

    // Reset in the middle of word 0 (after its 2nd byte).
    load_start = 1'b1; tick(); load_start = 1'b0;
    send(8'h00); send(8'h01); send(8'hAA); send(8'hBB);
    #2 reset_n = 1'b0;
    #1 chk_idle("rst_mid");
    tick();
    reset_n = 1'b1;
    tick();
    tx_q = {8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    run_load(0, 0);
    if (obs_q.size() == 1) chk("rst_reload", obs_q[0], {31'h0, 32'hAABBCCDD});

    // Full ROM boundary.
    gen(ROM);
    run_load(1, 0);

`ifdef LOADER_TIMEOUT_EN
    load_start = 1'b1; tick(); load_start = 1'b0;
    send(8'h00); send(8'h01); send(8'hAA);
    n = 0;
    while (!err && n < 40) begin
      tick();
      n++;
    end
    chk("timeout_cycles", n, 16);
    chk("timeout_hold", cpu_hold, 1);
`endif

    // Randomized sessions with ignored noise and variable byte gaps.
    for (int it = 0; it < 30; it++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0)      n = 0;
      else if (kind == 1) n = $urandom_range(ROM + 1, 65535);
      else                n = $urandom_range(1, 6);
      gen(n);
      run_load(1'($urandom_range(0, 1)), $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/uart_imem_loader.md
UART_IMEM_LOADER -- requirements
Module: uart_imem_loader

Interface
REQ-001 Parameter ROM_SIZE, default 256: instruction-memory depth in 32-bit words.
REQ-002 Parameter TIMEOUT_CYCLES, default 1000000: maximum idle clocks allowed between bytes (used only when LOADER_TIMEOUT_EN is defined).
REQ-003 Port clk  input  1: single clock; all state updates on the rising edge.
REQ-004 Port reset_n  input  1: reset, asynchronous and active-low.
REQ-005 Port load_start  input  1: one-cycle pulse that opens a load session.
REQ-006 Port rx_valid  input  1: one-cycle strobe from the UART receiver marking a received byte.
REQ-007 Port rx_data  input  8: byte from the receiver, valid while rx_valid=1.
REQ-008 Port wr_en  output  1: instruction-memory write strobe, one cycle per word.
REQ-009 Port wr_addr  output  31: byte address of the write, with bits [1:0]=0 and bits [30:2]=word index.
REQ-010 Port wr_data  output  32: instruction word to write.
REQ-011 Port cpu_hold  output  1: holds the CPU in reset while a session is active.
REQ-012 Port busy  output  1: high in states LEN_HI, LEN_LO and DATA.
REQ-013 Port done  output  1: one-cycle pulse when a load completes successfully.
REQ-014 Port err  output  1: sticky error flag.

Function
REQ-015 The FSM SHALL have the states IDLE, LEN_HI, LEN_LO, DATA, DONE and ERR.
REQ-016 Stream format: a 16-bit big-endian word count N, followed by N words of 4 bytes each, big-endian (MSB first).
REQ-017 In IDLE or ERR, load_start SHALL clear err and the internal counters, and go to LEN_HI; cpu_hold goes to 1 in the same edge.
REQ-018 In IDLE, rx_valid SHALL be ignored.
REQ-019 While busy=1, load_start SHALL be ignored.
REQ-020 LEN_HI: on rx_valid, latch count[15:8] and go to LEN_LO.
REQ-021 LEN_LO: on rx_valid, latch count[7:0], then branch on the full count:
- count==0: go to DONE.
- count>ROM_SIZE: go to ERR.
- otherwise: go to DATA.
REQ-022 DATA: each rx_valid SHALL shift rx_data into a 32-bit assembly register and advance a 2-bit byte counter.
REQ-023 On the 4th byte of a word:
- On the next cycle, wr_en=1 for exactly one cycle, wr_data=the assembled word, wr_addr={word_idx,2'b00}.
- word_idx then increments.
REQ-024 After the write of word N-1, the FSM SHALL go to DONE.
REQ-025 DONE SHALL last one cycle with done=1 and cpu_hold=0, then go to IDLE.
REQ-026 ERR: err=1 and cpu_hold=1 hold until load_start or reset; wr_en is never asserted in ERR.
REQ-027 word_idx SHALL never reach ROM_SIZE while writing.
REQ-028 wr_addr and wr_data SHALL hold their last values when wr_en=0.
REQ-029 rx_valid arriving in the same cycle as a wr_en pulse SHALL be accepted without loss.
REQ-030 Back-to-back rx_valid on consecutive cycles SHALL be supported.

Reset
REQ-031 Asserting reset_n=0 SHALL asynchronously force all of the following, including mid-session, with no partial write completed:
- state=IDLE.
- wr_en=0, wr_addr=0, wr_data=0.
- cpu_hold=0, busy=0, done=0, err=0.
- byte counter, word_idx and count all 0.
REQ-032 After reset_n returns to 1, the first load_start SHALL start a clean session.

Configuration
REQ-033 Macro LOADER_TIMEOUT_EN defined:
- An idle counter resets on every rx_valid and on entry to LEN_HI.
- In LEN_HI, LEN_LO or DATA, if TIMEOUT_CYCLES clocks pass without rx_valid, go to ERR.
REQ-034 Macro LOADER_TIMEOUT_EN undefined: no counter is present, and the FSM waits indefinitely for bytes.

Verification
REQ-035 load_start; bytes 00 02 08 00 00 03 08 00 00 15 -> wr_en pulse (addr 0x0, data 0x08000003), then wr_en pulse (addr 0x4, data 0x08000015), then one done pulse with cpu_hold falling.
REQ-036 load_start; bytes 00 00 -> done pulse one cycle after the LEN_LO byte, no wr_en pulse.
REQ-037 load_start; bytes 01 01 (count 257, ROM_SIZE=256) -> err=1, cpu_hold stays 1, no wr_en; a following load_start clears err.
REQ-038 reset_n pulsed low after the 2nd data byte of word 0 -> all outputs 0 immediately; a following load of 00 01 AA BB CC DD writes 0xAABBCCDD to addr 0x0.
REQ-039 With LOADER_TIMEOUT_EN defined and TIMEOUT_CYCLES=16: load_start, then bytes 00 01 AA, then idle -> err=1 after 16 idle clocks.
REQ-040 load_start pulsed during DATA, plus rx_valid during IDLE -> both ignored, and the write sequence is unchanged.
